uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning sample ticks per bit; legal values are even numbers of 4 or more.
- REQ-002 SHALL have parameter DIV_W, default 16, meaning width of the baud divisor input.
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
- REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
- REQ-005 SHALL have port baud_div_i, input, DIV_W bits: oversample tick period minus 1, in clk cycles.
- REQ-006 SHALL have port rx, input, 1 bit: asynchronous serial line; idle level is 1.
- REQ-007 SHALL have port rx_ack_i, input, 1 bit: consumer acknowledges the held byte.
- REQ-008 SHALL have port rx_data_o, output, 8 bits: held received byte.
- REQ-009 SHALL have port rx_valid_o, output, 1 bit: level signal; rx_data_o holds an unacknowledged byte.
- REQ-010 SHALL have port rx_frame_err_o, output, 1 bit: one-cycle pulse for a bad stop bit.
- REQ-011 SHALL have port rx_overrun_o, output, 1 bit: one-cycle pulse when a completed byte is dropped.
- REQ-012 SHALL have port rx_busy_o, output, 1 bit: 1 in any state other than IDLE.

Function
- REQ-013 SHALL pass rx through a 2-flop synchronizer (rx_s); both flops reset to 1, so reset never produces a false start.
- REQ-014 SHALL run a tick counter from 0 to baud_div_i, emitting tick when count == baud_div_i and then wrapping to 0; tick period is baud_div_i+1 cycles.
- REQ-015 SHALL clear the tick counter and the oversample counter on the IDLE->START transition, so sampling phase is referenced to the start edge.
- REQ-016 SHALL implement states IDLE, START, DATA, STOP.
- REQ-017 IDLE: when rx_s==0, go to START.
- REQ-018 START: on tick number OVERSAMPLE/2, sample rx_s.
  - 0: go to DATA with bit index 0.
  - 1: treat as glitch; return to IDLE with no flag.
- REQ-019 DATA: sample rx_s every OVERSAMPLE ticks after the start-bit sample (mid-bit) and shift into the data register LSB first.
  - After bit index 7 is sampled, go to STOP.
- REQ-020 STOP: OVERSAMPLE ticks after the last data sample, sample rx_s and return to IDLE in the same cycle.
  - IDLE is entered at mid-stop-bit, so a following start edge is detected.
- REQ-021 Stop sample 1, rx_valid_o==0 or rx_ack_i==1: load rx_data_o and set rx_valid_o on the next clock edge.
- REQ-022 Stop sample 1, rx_valid_o==1 and rx_ack_i==0: keep the old rx_data_o, drop the new byte, and pulse rx_overrun_o for 1 cycle.
- REQ-023 Stop sample 0: drop the byte, pulse rx_frame_err_o for 1 cycle, and leave rx_valid_o and rx_data_o unchanged.
- REQ-024 rx_ack_i with rx_valid_o==1 and no completion in the same cycle: clear rx_valid_o next cycle.
- REQ-025 rx_ack_i with rx_valid_o==0: ignore.
- REQ-026 Ack and completion in the same cycle: new byte is loaded, rx_valid_o stays 1, no overrun.
- REQ-027 Start-edge-to-state latency is 2 cycles (synchronizer); rx_valid_o rises 1 cycle after the stop-sample tick.
- REQ-028 baud_div_i SHALL be changed only while rx_busy_o==0; behaviour on a change mid-frame is undefined but SHALL NOT lock up (the counter compares with >=).
- REQ-029 No parity; 8N1 framing only.

Reset
- REQ-030 On rst_n low, immediately:
  - state=IDLE.
  - Tick counter, oversample counter, bit index and shift register all 0.
  - Synchronizer flops = 1.
  - rx_data_o=0x00, rx_valid_o=0, rx_frame_err_o=0, rx_overrun_o=0, rx_busy_o=0.
- REQ-031 Reset asserted mid-frame SHALL abandon the frame and raise no flags; after release, the block waits for rx_s high-to-low again.

Verification (baud_div_i=4: tick = 5 cycles, bit = 80 cycles)
- REQ-032 Drive frame 0xA5 (8N1, 80 cycles/bit) -> rx_valid_o=1, rx_data_o=0xA5, no error pulses; assert rx_ack_i 1 cycle -> rx_valid_o=0 next cycle.
- REQ-033 Drive rx low for 30 cycles then high -> rx_busy_o returns to 0; rx_valid_o, rx_frame_err_o and rx_overrun_o all stay 0.
- REQ-034 Drive 0x5A with stop bit 0 -> exactly one rx_frame_err_o pulse; rx_valid_o stays 0; rx_data_o unchanged.
- REQ-035 Drive 0x11 then 0x22 back-to-back with no ack -> rx_data_o=0x11, one rx_overrun_o pulse; after ack, rx_valid_o=0.
- REQ-036 Drive 0x33 and assert rx_ack_i in the stop-sample cycle while holding 0x44 -> rx_data_o=0x33, rx_valid_o stays 1, no overrun.
- REQ-037 Pulse rst_n low during bit 3 of a frame -> all outputs 0 immediately; the next full frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with an oversampled mid-bit sampler and a one-byte
// holding register that the consumer drains with a single-cycle acknowledge.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic             rx,
  input  logic             rx_ack_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  output logic             rx_frame_err_o,
  output logic             rx_overrun_o,
  output logic             rx_busy_o
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q;
  state_t           state_d;
  logic             rx_meta;
  logic             rx_s;
  logic [DIV_W-1:0] tick_cnt;
  logic             tick;
  logic [OS_W-1:0]  os_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;
  logic             start_det;
  logic             sample;
  logic             data_shift;
  logic             stop_ok;
  logic             stop_bad;

  // Two-flop synchronizer; both flops come out of reset at the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // >= rather than == so a divisor lowered mid-count cannot strand the counter.
  assign tick = (tick_cnt >= baud_div_i);

  // Tick and oversample counters, held at zero while idle so phase starts at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      os_cnt   <= '0;
    end else if (start_det || state_q == IDLE) begin
      tick_cnt <= '0;
      os_cnt   <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      os_cnt   <= sample ? '0 : os_cnt + 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and per-cycle sampling strobes.
  always_comb begin
    state_d    = state_q;
    start_det  = 1'b0;
    sample     = 1'b0;
    data_shift = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          start_det = 1'b1;
        end
      end
      START: begin
        if (tick && os_cnt == OS_HALF) begin
          sample  = 1'b1;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && os_cnt == OS_LAST) begin
          sample     = 1'b1;
          data_shift = 1'b1;
          if (bit_idx == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick && os_cnt == OS_LAST) begin
          sample   = 1'b1;
          state_d  = IDLE;
          stop_ok  = rx_s;
          stop_bad = !rx_s;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register collects data bits LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
      shift_q <= '0;
    end else if (state_q == START && sample) begin
      bit_idx <= '0;
    end else if (data_shift) begin
      shift_q <= {rx_s, shift_q[7:1]};
      bit_idx <= bit_idx + 1'b1;
    end
  end

  // Holding register, valid flag and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_o      <= '0;
      rx_valid_o     <= 1'b0;
      rx_frame_err_o <= 1'b0;
      rx_overrun_o   <= 1'b0;
    end else begin
      rx_frame_err_o <= stop_bad;
      rx_overrun_o   <= stop_ok && rx_valid_o && !rx_ack_i;
      if (stop_ok && (!rx_valid_o || rx_ack_i)) begin
        rx_data_o  <= shift_q;
        rx_valid_o <= 1'b1;
      end else if (rx_ack_i && rx_valid_o) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

  assign rx_busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at baud_div_i = 4 (80 clocks per bit).
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div_i = 16'd4;
  logic        rx = 1'b1;
  logic        rx_ack_i = 1'b0;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_frame_err_o;
  logic        rx_overrun_o;
  logic        rx_busy_o;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  uart_rx #(.OVERSAMPLE(16), .DIV_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .baud_div_i(baud_div_i),
    .rx(rx),
    .rx_ack_i(rx_ack_i),
    .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o),
    .rx_frame_err_o(rx_frame_err_o),
    .rx_overrun_o(rx_overrun_o),
    .rx_busy_o(rx_busy_o)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_frame_err_o) fe_cnt++;
    if (rx_overrun_o)   ov_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame, 800 clocks; optional ack in the stop-sample cycle (edge 763).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic ack_at_stop);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    @(posedge clk); #1;
    for (int c = 0; c < 800; c++) begin
      rx = f[c / 80];
      rx_ack_i = ack_at_stop && (c == 762);
      @(posedge clk); #1;
    end
    rx = 1'b1;
    rx_ack_i = 1'b0;
  endtask

  task automatic pulse_ack();
    rx_ack_i = 1'b1;
    @(posedge clk); #1;
    rx_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (rx_valid_o !== 1'b0 || rx_data_o !== 8'h00 || rx_busy_o !== 1'b0 ||
        rx_frame_err_o !== 1'b0 || rx_overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h busy=%b fe=%b ov=%b, required all 0",
               rx_valid_o, rx_data_o, rx_busy_o, rx_frame_err_o, rx_overrun_o);
    end
    idle(3);
    rst_n = 1'b1;
    idle(20);
    @(negedge clk);
    checks++;
    if (rx_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: busy=%b, required 0", rx_busy_o);
    end
  endtask

  task automatic test_basic();
    int fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (rx_valid_o !== 1'b1 || rx_data_o !== 8'hA5) begin
      errors++;
      $display("FAIL basic_rx: valid=%b data=%h, required 1 a5", rx_valid_o, rx_data_o);
    end
    checks++;
    if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin
      errors++;
      $display("FAIL basic_flags: fe=%0d ov=%0d, required 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
    idle(1);
    pulse_ack();
    @(negedge clk);
    checks++;
    if (rx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack: valid=%b, required 0", rx_valid_o);
    end
    idle(50);
  endtask

  task automatic test_glitch();
    int fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    rx = 1'b0;
    idle(20);
    checks++;
    if (rx_busy_o !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_during: busy=%b, required 1", rx_busy_o);
    end
    idle(10);
    rx = 1'b1;
    idle(60);
    @(negedge clk);
    checks++;
    if (rx_busy_o !== 1'b0 || rx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL glitch_return: busy=%b valid=%b, required 0 0", rx_busy_o, rx_valid_o);
    end
    checks++;
    if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin
      errors++;
      $display("FAIL glitch_flags: fe=%0d ov=%0d, required 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_frame_err();
    int fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h5A, 1'b0, 1'b0);
    idle(150);
    @(negedge clk);
    checks++;
    if (fe_cnt - fe0 !== 1) begin
      errors++;
      $display("FAIL frame_err_pulses: got %0d, required 1", fe_cnt - fe0);
    end
    checks++;
    if (rx_valid_o !== 1'b0 || rx_data_o !== 8'hA5 || ov_cnt - ov0 !== 0) begin
      errors++;
      $display("FAIL frame_err_hold: valid=%b data=%h ov=%0d, required 0 a5 0",
               rx_valid_o, rx_data_o, ov_cnt - ov0);
    end
  endtask

  task automatic test_back_to_back();
    int ov0;
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h11) begin
      errors++;
      $display("FAIL b2b_first: valid=%b data=%h, required 1 11", rx_valid_o, rx_data_o);
    end
    send_frame(8'h22, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (rx_data_o !== 8'h11 || rx_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hold: valid=%b data=%h, required 1 11", rx_valid_o, rx_data_o);
    end
    checks++;
    if (ov_cnt - ov0 !== 1) begin
      errors++;
      $display("FAIL b2b_overrun: got %0d pulses, required 1", ov_cnt - ov0);
    end
    idle(1);
    pulse_ack();
    @(negedge clk);
    checks++;
    if (rx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ack: valid=%b, required 0", rx_valid_o);
    end
    idle(50);
  endtask

  task automatic test_ack_at_stop();
    int ov0;
    send_frame(8'h44, 1'b1, 1'b0);
    idle(20);
    ov0 = ov_cnt;
    send_frame(8'h33, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h33) begin
      errors++;
      $display("FAIL ack_stop_load: valid=%b data=%h, required 1 33", rx_valid_o, rx_data_o);
    end
    checks++;
    if (ov_cnt - ov0 !== 0) begin
      errors++;
      $display("FAIL ack_stop_overrun: got %0d pulses, required 0", ov_cnt - ov0);
    end
    idle(20);
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] f;
    int fe0, ov0;
    f = {1'b1, 8'h96, 1'b0};
    @(posedge clk); #1;
    for (int c = 0; c < 350; c++) begin
      rx = f[c / 80];
      @(posedge clk); #1;
    end
    checks++;
    if (rx_busy_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy_before: busy=%b, required 1", rx_busy_o);
    end
    rst_n = 1'b0;
    rx = 1'b1;
    #2;
    checks++;
    if (rx_valid_o !== 1'b0 || rx_data_o !== 8'h00 || rx_busy_o !== 1'b0 ||
        rx_frame_err_o !== 1'b0 || rx_overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: valid=%b data=%h busy=%b fe=%b ov=%b, required all 0",
               rx_valid_o, rx_data_o, rx_busy_o, rx_frame_err_o, rx_overrun_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt;
    idle(100);
    send_frame(8'h3C, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h3C) begin
      errors++;
      $display("FAIL midrst_next_frame: valid=%b data=%h, required 1 3c", rx_valid_o, rx_data_o);
    end
    checks++;
    if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin
      errors++;
      $display("FAIL midrst_flags: fe=%0d ov=%0d, required 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_ack_at_stop();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
